// File: rtl/modinv_helper_cmp_if.sv
// Bus between the modular-inversion loop controller / u,v buffers and the
// decision stage: start handshake, buffer read ports and result flags.
interface modinv_helper_cmp_if #(
   parameter int unsigned BUFFER_ADDR_BITS = 4
);

   logic                        ena;
   logic                        rdy;
   logic [BUFFER_ADDR_BITS-1:0] u_addr;
   logic [BUFFER_ADDR_BITS-1:0] v_addr;
   logic [31:0]                 u_din;
   logic [31:0]                 v_din;
   logic                        v_is_zero;
   logic                        u_is_even;
   logic                        v_is_even;
   logic                        u_gt_v;

   // Controller / buffer side
   modport master (
      output ena, u_din, v_din,
      input  rdy, u_addr, v_addr, v_is_zero, u_is_even, v_is_even, u_gt_v
   );

   // Decision stage side
   modport slave (
      input  ena, u_din, v_din,
      output rdy, u_addr, v_addr, v_is_zero, u_is_even, v_is_even, u_gt_v
   );

endinterface

// File: rtl/modinv_helper_cmp.sv
// Decision stage of the modular-inversion loop: streams u and v (LSW first)
// and produces v==0, u even, v even and u>v for the loop controller.
module modinv_helper_cmp #(
   parameter int unsigned BUFFER_NUM_WORDS = 9,
   parameter int unsigned BUFFER_ADDR_BITS = 4
) (
   input logic               clk,
   input logic               rst_n,
   modinv_helper_cmp_if.slave bus
);

   localparam int unsigned PROC_NUM_CYCLES = BUFFER_NUM_WORDS + 3;
   localparam int unsigned CNT_BITS        = $clog2(PROC_NUM_CYCLES);

   // Counter landmarks: last address issue, first/last data word, commit
   localparam logic [CNT_BITS-1:0] CNT_ADDR_LAST  = CNT_BITS'(BUFFER_NUM_WORDS - 1);
   localparam logic [CNT_BITS-1:0] CNT_WORD_FIRST = CNT_BITS'(2);
   localparam logic [CNT_BITS-1:0] CNT_WORD_LAST  = CNT_BITS'(BUFFER_NUM_WORDS + 1);
   localparam logic [CNT_BITS-1:0] CNT_COMMIT     = CNT_BITS'(PROC_NUM_CYCLES - 1);

   logic [CNT_BITS-1:0]         proc_cnt;
   logic [BUFFER_ADDR_BITS-1:0] addr;

   logic borrow_acc;
   logic zero_acc;
   logic u_even_acc;
   logic v_even_acc;

   logic v_is_zero_r;
   logic u_is_even_r;
   logic v_is_even_r;
   logic u_gt_v_r;

   logic        borrow_in;
   logic [32:0] diff;
   logic        v_word_zero;
   logic        word_first;
   logic        word_rest;

   // Word-serial v - u; the final borrow-out means v < u, i.e. u > v
   always_comb begin
      word_first  = (proc_cnt == CNT_WORD_FIRST);
      word_rest   = (proc_cnt > CNT_WORD_FIRST) && (proc_cnt <= CNT_WORD_LAST);
      borrow_in   = word_first ? 1'b0 : borrow_acc;
      diff        = {1'b0, bus.v_din} - {1'b0, bus.u_din} - {32'd0, borrow_in};
      v_word_zero = (bus.v_din == '0);
   end

   // Run counter: idle at 0, started by ena, free-runs to the commit slot and wraps
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         proc_cnt <= '0;
      end else if (proc_cnt == '0) begin
         if (bus.ena) proc_cnt <= CNT_BITS'(1);
      end else if (proc_cnt == CNT_COMMIT) begin
         proc_cnt <= '0;
      end else begin
         proc_cnt <= proc_cnt + 1'b1;
      end
   end

   // Shared u/v read address: walks 0..N-1 while proc_cnt is 1..N, else parked at 0
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr <= '0;
      end else if ((proc_cnt != '0) && (proc_cnt <= CNT_ADDR_LAST)) begin
         addr <= addr + 1'b1;
      end else begin
         addr <= '0;
      end
   end

   // Per-word accumulation; word 0 seeds the borrow, zero and parity state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         borrow_acc <= 1'b0;
         zero_acc   <= 1'b0;
         u_even_acc <= 1'b0;
         v_even_acc <= 1'b0;
      end else if (word_first) begin
         borrow_acc <= diff[32];
         zero_acc   <= v_word_zero;
         u_even_acc <= ~bus.u_din[0];
         v_even_acc <= ~bus.v_din[0];
      end else if (word_rest) begin
         borrow_acc <= diff[32];
         zero_acc   <= zero_acc & v_word_zero;
      end
   end

   // Flags change only on the commit edge, together with rdy returning high
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_is_zero_r <= 1'b0;
         u_is_even_r <= 1'b0;
         v_is_even_r <= 1'b0;
         u_gt_v_r    <= 1'b0;
      end else if (proc_cnt == CNT_COMMIT) begin
         v_is_zero_r <= zero_acc;
         u_is_even_r <= u_even_acc;
         v_is_even_r <= v_even_acc;
         u_gt_v_r    <= borrow_acc;
      end
   end

   assign bus.rdy       = (proc_cnt == '0);
   assign bus.u_addr    = addr;
   assign bus.v_addr    = addr;
   assign bus.v_is_zero = v_is_zero_r;
   assign bus.u_is_even = u_is_even_r;
   assign bus.v_is_even = v_is_even_r;
   assign bus.u_gt_v    = u_gt_v_r;

endmodule
